// File: rtl/sa_ctrl_pkg.sv
// Shared types for the sub_array tile sequencer: FSM states and the
// dataflow_sel encodings understood by the sub_array.
package sa_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRELOAD = 2'd1,
      STREAM  = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [1:0] DF_WS = 2'b00;  // weight-stationary
   localparam logic [1:0] DF_IS = 2'b01;  // ifmap-stationary
   localparam logic [1:0] DF_OS = 2'b10;  // output-stationary

endpackage

// File: rtl/sa_skew_gen.sv
// Skew window generator: turns the stream cycle count t and vector count K
// into registered per-row feed masks/indices and per-column psum-valid flags.
module sa_skew_gen
   import sa_ctrl_pkg::*;
#(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int K_W   = 8,
   parameter int CNT_W = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  active,
   input  logic [CNT_W-1:0]      t,
   input  logic [K_W-1:0]        k,
   output logic [ROWS-1:0]       row_feed_en,
   output logic [ROWS*K_W-1:0]   row_feed_idx,
   output logic [COLS-1:0]       col_out_valid
);

   logic [CNT_W-1:0]    k_ext;
   logic [ROWS-1:0]     en_d;
   logic [ROWS*K_W-1:0] idx_d;
   logic [COLS-1:0]     cov_d;

   // Window upper bounds are formed at CNT_W bits so K at its max cannot wrap.
   assign k_ext = {{(CNT_W-K_W){1'b0}}, k};

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam logic [CNT_W-1:0] R  = CNT_W'(r);
      localparam logic [K_W-1:0]   RK = K_W'(r);
      assign en_d[r] = active && (t >= R) && (t < R + k_ext);
      // Inside the window t-r < K, so the low K_W bits carry the full index.
      assign idx_d[r*K_W +: K_W] = en_d[r] ? (t[K_W-1:0] - RK) : '0;
   end

   for (genvar c = 0; c < COLS; c++) begin : g_col
      localparam logic [CNT_W-1:0] C0 = CNT_W'(ROWS + c);
      assign cov_d[c] = active && (t >= C0) && (t < C0 + k_ext);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_feed_en   <= '0;
         row_feed_idx  <= '0;
         col_out_valid <= '0;
      end else begin
         row_feed_en   <= en_d;
         row_feed_idx  <= idx_d;
         col_out_valid <= cov_d;
      end
   end

endmodule

// File: rtl/sub_array_ctrl.sv
// Tile-job sequencer for a ROWS x COLS weight-stationary sub_array:
// weight preload, skewed ifmap streaming and South-edge psum-valid flags.
module sub_array_ctrl
   import sa_ctrl_pkg::*;
#(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int K_W   = 8,
   parameter int CNT_W = 10
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      abort,
   input  logic [1:0]                cfg_dataflow,
   input  logic [K_W-1:0]            cfg_k,
   output logic                      busy,
   output logic                      done,
   output logic [1:0]                dataflow_sel,
   output logic                      stationary_sel,
   output logic                      wt_rd_en,
   output logic [$clog2(ROWS)-1:0]   wt_rd_row,
   output logic [ROWS-1:0]           row_feed_en,
   output logic [ROWS*K_W-1:0]       row_feed_idx,
   output logic [COLS-1:0]           col_out_valid
);

   localparam int               RW       = $clog2(ROWS);
   localparam logic [CNT_W-1:0] ROWS_M1  = CNT_W'(ROWS - 1);
   localparam logic [CNT_W-1:0] LAST_OFF = CNT_W'(ROWS + COLS - 2);

   state_t           state, state_d;
   logic [CNT_W-1:0] t, t_d;
   logic [K_W-1:0]   k_q, k_d;
   logic [CNT_W-1:0] stream_last;

   assign stream_last = {{(CNT_W-K_W){1'b0}}, k_q} + LAST_OFF;

   always_comb begin
      state_d = state;
      t_d     = t;
      k_d     = k_q;
      case (state)
         IDLE: begin
            if (start) begin
               state_d = PRELOAD;
               t_d     = '0;
               k_d     = cfg_k;
            end
         end
         PRELOAD: begin
            if (abort) begin
               state_d = IDLE;
               t_d     = '0;
            end else if (t == ROWS_M1) begin
               state_d = (k_q == '0) ? DONE : STREAM;
               t_d     = '0;
            end else begin
               t_d = t + 1'b1;
            end
         end
         STREAM: begin
            if (abort) begin
               state_d = IDLE;
               t_d     = '0;
            end else if (t == stream_last) begin
               state_d = DONE;
               t_d     = '0;
            end else begin
               t_d = t + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            t_d     = '0;
         end
         default: begin
            state_d = IDLE;
            t_d     = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the
   // state they describe; done trails DONE by one cycle and busy covers it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         t              <= '0;
         k_q            <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         dataflow_sel   <= DF_WS;
         stationary_sel <= 1'b0;
         wt_rd_en       <= 1'b0;
         wt_rd_row      <= '0;
      end else begin
         state          <= state_d;
         t              <= t_d;
         k_q            <= k_d;
         busy           <= (state_d != IDLE) || (state == DONE);
         done           <= (state == DONE);
         if (state == IDLE && start)
            dataflow_sel <= cfg_dataflow;
         stationary_sel <= (state_d == PRELOAD);
         wt_rd_en       <= (state_d == PRELOAD);
         wt_rd_row      <= (state_d == PRELOAD) ? RW'(ROWS_M1 - t_d) : '0;
      end
   end

   sa_skew_gen #(
      .ROWS  (ROWS),
      .COLS  (COLS),
      .K_W   (K_W),
      .CNT_W (CNT_W)
   ) u_skew (
      .clk           (clk),
      .rst           (rst),
      .active        (state_d == STREAM),
      .t             (t_d),
      .k             (k_d),
      .row_feed_en   (row_feed_en),
      .row_feed_idx  (row_feed_idx),
      .col_out_valid (col_out_valid)
   );

endmodule
